// File: rtl/axi_st_patgen.sv
// AXI-Stream pattern generator.
// Emits counted or continuous bursts of test patterns (lane index, walking
// one, LFSR, alternating 5/A). One enable level yields exactly one burst.
// Handshake: a beat transfers only when tvalid and tready are both high in
// the same cycle. Once tvalid is raised it stays high, with tdata/tlast
// frozen, until that beat is accepted.
module axi_st_patgen #(
   parameter int DWIDTH = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              csr_patgen_en,
   input  logic [1:0]        csr_patgen_sel,
   input  logic [8:0]        csr_patgen_cnt,
   input  logic              csr_cntuspatt_en,
   input  logic              tready,
   output logic              tvalid,
   output logic [DWIDTH-1:0] tdata,
   output logic              tlast,
   output logic              patgen_busy,
   output logic              patgen_done
);

   localparam int          LANES     = DWIDTH / 32;
   localparam logic [31:0] LFSR_SEED = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      WAIT_LOW = 2'd2
   } state_t;

   // Current FSM state; kept as a named signal so checkers can bind to it.
   state_t      state;

   // Burst settings captured on entry to RUN.
   logic [1:0]  sel_q;
   logic [8:0]  cnt_q;
   logic        cont_q;

   logic [15:0] beat_idx;
   logic [31:0] lfsr;

   logic        accept;
   logic [15:0] idx_nxt;
   logic [31:0] lfsr_nxt;
   logic [15:0] last_idx;

   // Builds the beat payload for a given index and LFSR value.
   function automatic logic [DWIDTH-1:0] pattern(input logic [1:0]  sel,
                                                 input logic [15:0] idx,
                                                 input logic [31:0] lfsr_val);
      logic [DWIDTH-1:0] pat;
      logic [31:0]       bit_pos;
      pat     = '0;
      bit_pos = {16'h0, idx} % 32'(DWIDTH);
      case (sel)
         2'b00:   pat = {LANES{16'h0, idx}};
         2'b01:   pat = {{(DWIDTH-1){1'b0}}, 1'b1} << bit_pos;
         2'b10:   pat = {LANES{lfsr_val}};
         default: pat = {LANES{idx[0] ? 32'hAAAA_AAAA : 32'h5555_5555}};
      endcase
      return pat;
   endfunction

   assign accept   = tvalid & tready;
   assign idx_nxt  = beat_idx + 16'd1;
   // Fibonacci LFSR, taps x^32 + x^22 + x^2 + x + 1.
   assign lfsr_nxt = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
   // Counted mode never starts with cnt=0, so this subtraction cannot wrap there.
   assign last_idx = {7'd0, cnt_q} - 16'd1;

   // FSM with all stream outputs registered (no input-to-output combinational path).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         sel_q       <= 2'b00;
         cnt_q       <= 9'd0;
         cont_q      <= 1'b0;
         beat_idx    <= 16'd0;
         lfsr        <= LFSR_SEED;
         tvalid      <= 1'b0;
         tdata       <= '0;
         tlast       <= 1'b0;
         patgen_busy <= 1'b0;
         patgen_done <= 1'b0;
      end else begin
         patgen_done <= 1'b0;
         case (state)
            IDLE: begin
               if (csr_patgen_en) begin
                  if (csr_cntuspatt_en || (csr_patgen_cnt != 9'd0)) begin
                     state       <= RUN;
                     patgen_busy <= 1'b1;
                     sel_q       <= csr_patgen_sel;
                     cnt_q       <= csr_patgen_cnt;
                     cont_q      <= csr_cntuspatt_en;
                     beat_idx    <= 16'd0;
                     lfsr        <= LFSR_SEED;
                  end else begin
                     // Zero-length counted burst: report completion, send nothing.
                     state       <= WAIT_LOW;
                     patgen_done <= 1'b1;
                  end
               end
            end

            RUN: begin
               if (!tvalid) begin
                  // First RUN cycle: present beat 0 one cycle after entry.
                  tvalid <= 1'b1;
                  tdata  <= pattern(sel_q, beat_idx, lfsr);
                  tlast  <= !cont_q && (cnt_q == 9'd1);
               end else if (accept) begin
                  beat_idx <= idx_nxt;
                  lfsr     <= lfsr_nxt;
                  if (tlast || !csr_patgen_en) begin
                     tvalid      <= 1'b0;
                     tlast       <= 1'b0;
                     patgen_busy <= 1'b0;
                     patgen_done <= 1'b1;
                     state       <= WAIT_LOW;
                  end else begin
                     tdata <= pattern(sel_q, idx_nxt, lfsr_nxt);
                     tlast <= !cont_q && (idx_nxt == last_idx);
                  end
               end
            end

            WAIT_LOW: begin
               if (!csr_patgen_en) begin
                  state <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/axi_st_patgen.md
AXI_ST_PATGEN -- requirements
Module: axi_st_patgen

Interface
REQ-001 SHALL have parameter DWIDTH, default 64: tdata width; a multiple of 32, minimum 32.
REQ-002 SHALL have port clk, input, 1: the single clock for all logic.
REQ-003 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port csr_patgen_en, input, 1: run request, level-sensitive.
REQ-005 SHALL have port csr_patgen_sel, input, 2: pattern select.
REQ-006 SHALL have port csr_patgen_cnt, input, 9: burst length in beats.
REQ-007 SHALL have port csr_cntuspatt_en, input, 1: continuous mode, which ignores cnt.
REQ-008 SHALL have port tready, input, 1: downstream ready.
REQ-009 SHALL have port tvalid, output, 1: beat valid.
REQ-010 SHALL have port tdata, output, DWIDTH: beat data.
REQ-011 SHALL have port tlast, output, 1: final beat of a counted burst.
REQ-012 SHALL have port patgen_busy, output, 1: high in state RUN.
REQ-013 SHALL have port patgen_done, output, 1: single-cycle pulse at the end of a burst or stop.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and WAIT_LOW.
REQ-015 SHALL transition IDLE->RUN when csr_patgen_en=1 and (csr_cntuspatt_en=1 or csr_patgen_cnt!=0).
REQ-016 SHALL transition IDLE->WAIT_LOW with a patgen_done pulse and no beats when csr_patgen_en=1, csr_patgen_cnt=0 and csr_cntuspatt_en=0.
REQ-017 SHALL, on IDLE->RUN, capture sel, cnt and cntuspatt_en into internal registers; changes to those inputs during RUN SHALL be ignored.
REQ-018 SHALL assert tvalid the cycle after entry to RUN (one-cycle start latency) and hold tvalid=1 every RUN cycle until termination.
REQ-019 SHALL treat a beat as accepted only when tvalid=1 and tready=1 in the same cycle.
REQ-020 SHALL keep tdata and tlast stable while tvalid=1 and tready=0.
REQ-021 SHALL keep a 16-bit beat index, cleared on entry to RUN and incremented by one per accepted beat, wrapping 0xFFFF->0x0000.
REQ-022 SHALL generate tdata for sel=00 as the 32-bit word {16'h0, beat index} replicated across all 32-bit lanes.
REQ-023 SHALL generate tdata for sel=01 as walking-one data: only bit (beat index mod DWIDTH) set.
REQ-024 SHALL generate tdata for sel=10 from a 32-bit Fibonacci LFSR, taps x^32+x^22+x^2+x+1, seeded 32'hFFFF_FFFF on entry to RUN, advanced once per accepted beat, current value replicated across all lanes.
REQ-025 SHALL generate tdata for sel=11 as all-lanes 32'h5555_5555 when the beat index is even and 32'hAAAA_AAAA when it is odd.
REQ-026 SHALL, in counted mode, assert tlast only on beat index = captured cnt-1; acceptance of that beat terminates the burst.
REQ-027 SHALL, in continuous mode, hold tlast=0 and run until csr_patgen_en=0.
REQ-028 SHALL, when csr_patgen_en falls during RUN with tvalid=1, keep the pending beat until accepted (no tvalid drop), then terminate; a tlast beat accepted in the same cycle SHALL terminate normally.
REQ-029 SHALL, on termination, deassert tvalid the next cycle, pulse patgen_done for one cycle, and move to WAIT_LOW.
REQ-030 SHALL leave WAIT_LOW for IDLE only when csr_patgen_en=0, so one enable level yields exactly one burst.
REQ-031 SHALL produce no combinational path from any input to tvalid, tdata or tlast.

Reset
REQ-032 SHALL, on asynchronous assertion of rst_n=0, drive state=IDLE, tvalid=0, tlast=0, tdata=0, patgen_busy=0, patgen_done=0, beat index=0 and LFSR=32'hFFFF_FFFF.
REQ-033 SHALL, on reset asserted mid-burst, abort immediately; after release it SHALL restart only on csr_patgen_en=1 sampled in IDLE.
REQ-034 SHALL have rst_n deassertion synchronized externally; the block itself adds no synchronizer.

Verification
REQ-035 SHALL be verified with: sel=00, cnt=4, tready=1, en 0->1 -> 4 beats on consecutive cycles, lanes 0,1,2,3, tlast on the 4th, one done pulse, busy low afterward.
REQ-036 SHALL be verified with: sel=10, cnt=3, tready toggling 1,0,1,0 -> beats FFFF_FFFF then the next two LFSR values, data stable during stalls, exactly 3 handshakes.
REQ-037 SHALL be verified with: cnt=0, cntuspatt=0, en=1 -> no tvalid, done pulses once, en held high gives no further activity.
REQ-038 SHALL be verified with: cntuspatt=1, sel=11, en high 10 cycles with tready=0 at the drop -> alternating 5555/AAAA beats, tlast=0 throughout, last beat held until accepted, then done.
REQ-039 SHALL be verified with: sel=01, DWIDTH=64, cnt=66 -> bit 0 set on beat 0 and on beat 64, bit 1 set on beat 65 (tlast).
REQ-040 SHALL be verified with: rst_n pulsed low on beat 2 of a cnt=8 burst -> tvalid=0 at once, all outputs at reset values, a new burst restarts at index 0.
